// File: rtl/decode_2r12i_stage_pkg.sv
// Shared definitions for the 2R12I decode stage: op codes, class-field
// selectors and the per-lane decoded record.
package decode_2r12i_stage_pkg;

    localparam logic [3:0] _2R12I_SLTI   = 4'd0;
    localparam logic [3:0] _2R12I_SLTUI  = 4'd1;
    localparam logic [3:0] _2R12I_ADDI   = 4'd2;
    localparam logic [3:0] _2R12I_ANDI   = 4'd3;
    localparam logic [3:0] _2R12I_ORI    = 4'd4;
    localparam logic [3:0] _2R12I_XORI   = 4'd5;
    localparam logic [3:0] _2R12I_LD_B   = 4'd6;
    localparam logic [3:0] _2R12I_LD_H   = 4'd7;
    localparam logic [3:0] _2R12I_LD_W   = 4'd8;
    localparam logic [3:0] _2R12I_ST_B   = 4'd9;
    localparam logic [3:0] _2R12I_ST_H   = 4'd10;
    localparam logic [3:0] _2R12I_ST_W   = 4'd11;
    localparam logic [3:0] _2R12I_LD_BU  = 4'd12;
    localparam logic [3:0] _2R12I_LD_HU  = 4'd13;
    localparam logic [3:0] _2R12I_PRELD  = 4'd14;
    localparam logic [3:0] INVALID_OP_4B = 4'd15;

    // Group selector is {instr[29], instr[27]}.
    localparam logic [1:0] GRP_ALU = 2'b00;
    localparam logic [1:0] GRP_MEM = 2'b11;

    // ALU selector is instr[24:22] (instr[25] must be 1).
    localparam logic [2:0] ALU_SEL_SLTI  = 3'b000;
    localparam logic [2:0] ALU_SEL_SLTUI = 3'b001;
    localparam logic [2:0] ALU_SEL_ADDI  = 3'b010;
    localparam logic [2:0] ALU_SEL_ANDI  = 3'b101;
    localparam logic [2:0] ALU_SEL_ORI   = 3'b110;
    localparam logic [2:0] ALU_SEL_XORI  = 3'b111;

    // Memory selector is instr[25:22].
    localparam logic [3:0] MEM_SEL_LD_B  = 4'b0000;
    localparam logic [3:0] MEM_SEL_LD_H  = 4'b0001;
    localparam logic [3:0] MEM_SEL_LD_W  = 4'b0010;
    localparam logic [3:0] MEM_SEL_ST_B  = 4'b0100;
    localparam logic [3:0] MEM_SEL_ST_H  = 4'b0101;
    localparam logic [3:0] MEM_SEL_ST_W  = 4'b0110;
    localparam logic [3:0] MEM_SEL_LD_BU = 4'b1000;
    localparam logic [3:0] MEM_SEL_LD_HU = 4'b1001;
    localparam logic [3:0] MEM_SEL_PRELD = 4'b1011;

    typedef struct packed {
        logic [3:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rj;
        logic [31:0] imm;
        logic        illegal;
    } decoded_2r12i_t;

    // Logical immediates are unsigned; everything else sign-extends si12.
    function automatic logic is_zext(input logic [3:0] op);
        return (op == _2R12I_ANDI) || (op == _2R12I_ORI) || (op == _2R12I_XORI);
    endfunction

endpackage

// File: rtl/decode_2r12i_lane.sv
// Combinational decode of one 2R12I instruction into op, registers and
// extended immediate; masked-off lanes produce an inert INVALID record.
module decode_2r12i_lane
    import decode_2r12i_stage_pkg::*;
(
    input  logic [31:0]    instr,
    input  logic           lane_valid,
    output decoded_2r12i_t dec
);

    logic [3:0]  op;
    logic [11:0] si12;

    assign si12 = instr[21:10];

    // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
    always_comb begin
        op = INVALID_OP_4B;
        if ({instr[31:30], instr[28], instr[26]} == 4'b0000) begin
            if (({instr[29], instr[27]} == GRP_ALU) && instr[25]) begin
                case (instr[24:22])
                    ALU_SEL_SLTI:  op = _2R12I_SLTI;
                    ALU_SEL_SLTUI: op = _2R12I_SLTUI;
                    ALU_SEL_ADDI:  op = _2R12I_ADDI;
                    ALU_SEL_ANDI:  op = _2R12I_ANDI;
                    ALU_SEL_ORI:   op = _2R12I_ORI;
                    ALU_SEL_XORI:  op = _2R12I_XORI;
                    default:       op = INVALID_OP_4B;
                endcase
            end else if ({instr[29], instr[27]} == GRP_MEM) begin
                case (instr[25:22])
                    MEM_SEL_LD_B:  op = _2R12I_LD_B;
                    MEM_SEL_LD_H:  op = _2R12I_LD_H;
                    MEM_SEL_LD_W:  op = _2R12I_LD_W;
                    MEM_SEL_ST_B:  op = _2R12I_ST_B;
                    MEM_SEL_ST_H:  op = _2R12I_ST_H;
                    MEM_SEL_ST_W:  op = _2R12I_ST_W;
                    MEM_SEL_LD_BU: op = _2R12I_LD_BU;
                    MEM_SEL_LD_HU: op = _2R12I_LD_HU;
                    MEM_SEL_PRELD: op = _2R12I_PRELD;
                    default:       op = INVALID_OP_4B;
                endcase
            end
        end
    end

    always_comb begin
        dec    = '0;
        dec.op = INVALID_OP_4B;
        if (lane_valid) begin
            dec.op = op;
            dec.rd = instr[4:0];
            dec.rj = instr[9:5];
            if (op == INVALID_OP_4B) begin
                dec.illegal = 1'b1;
            end else if (is_zext(op)) begin
                dec.imm = {20'b0, si12};
            end else begin
                dec.imm = {{20{si12[11]}}, si12};
            end
        end
    end

endmodule

// File: rtl/decode_2r12i_stage.sv
// Multi-lane 2R12I decode stage: one decode register (D) feeding a
// DEPTH-entry FIFO of decoded bundles, with flush and illegal-op counting.
module decode_2r12i_stage
    import decode_2r12i_stage_pkg::*;
#(
    parameter int LANES = 2,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES-1:0]      in_mask,
    input  logic [32*LANES-1:0]   in_instr,
    input  logic [32*LANES-1:0]   in_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES-1:0]      out_mask,
    output logic [4*LANES-1:0]    out_op,
    output logic [5*LANES-1:0]    out_rd,
    output logic [5*LANES-1:0]    out_rj,
    output logic [32*LANES-1:0]   out_imm,
    output logic [32*LANES-1:0]   out_pc,
    output logic [LANES-1:0]      out_illegal,
    output logic [CNT_W-1:0]      illegal_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

    decoded_2r12i_t [LANES-1:0] lane_dec;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        decode_2r12i_lane u_lane (
            .instr      (in_instr[32*g +: 32]),
            .lane_valid (in_mask[g]),
            .dec        (lane_dec[g])
        );
    end

    logic                       d_valid;
    logic [LANES-1:0]           d_mask;
    decoded_2r12i_t [LANES-1:0] d_dec;
    logic [32*LANES-1:0]        d_pc;

    decoded_2r12i_t [LANES-1:0] fifo_dec  [DEPTH];
    logic [LANES-1:0]           fifo_mask [DEPTH];
    logic [32*LANES-1:0]        fifo_pc   [DEPTH];

    logic [PW:0]   wr_ptr, rd_ptr, count;
    logic [PW-1:0] rd_idx;
    logic          empty, full, load, fifo_wr, fifo_rd;

    assign count    = wr_ptr - rd_ptr;
    assign rd_idx   = rd_ptr[PW-1:0];
    assign empty    = (count == '0);
    assign full     = (count == FULL_CNT);
    // Registered-only admission: bundles held in D count against capacity.
    assign in_ready = ({1'b0, count} + {{(PW+1){1'b0}}, d_valid}) < {1'b0, FULL_CNT};

    assign load    = in_valid && in_ready && !flush;
    assign fifo_rd = !empty && out_ready && !flush;
    assign fifo_wr = d_valid && (!full || fifo_rd) && !flush;

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_valid <= 1'b0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
        end else if (flush) begin
            d_valid <= 1'b0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
        end else begin
            if (load) begin
                d_valid <= 1'b1;
            end else if (fifo_wr) begin
                d_valid <= 1'b0;
            end
            if (fifo_wr) wr_ptr <= wr_ptr + 1'b1;
            if (fifo_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: data payloads and FIFO storage carry no reset; d_valid and the pointers gate every use.
    always_ff @(posedge clk) begin
        if (load) begin
            d_mask <= in_mask;
            d_dec  <= lane_dec;
            d_pc   <= in_pc;
        end
        if (fifo_wr) begin
            fifo_dec[wr_ptr[PW-1:0]]  <= d_dec;
            fifo_mask[wr_ptr[PW-1:0]] <= d_mask;
            fifo_pc[wr_ptr[PW-1:0]]   <= d_pc;
        end
    end

    assign out_valid = !empty;

    always_comb begin
        out_mask    = '0;
        out_op      = '0;
        out_rd      = '0;
        out_rj      = '0;
        out_imm     = '0;
        out_pc      = '0;
        out_illegal = '0;
        if (!empty) begin
            out_mask = fifo_mask[rd_idx];
            out_pc   = fifo_pc[rd_idx];
            for (int i = 0; i < LANES; i++) begin
                out_op[4*i +: 4]   = fifo_dec[rd_idx][i].op;
                out_rd[5*i +: 5]   = fifo_dec[rd_idx][i].rd;
                out_rj[5*i +: 5]   = fifo_dec[rd_idx][i].rj;
                out_imm[32*i +: 32] = fifo_dec[rd_idx][i].imm;
                out_illegal[i]     = fifo_dec[rd_idx][i].illegal;
            end
        end
    end

    logic [2:0]     pop_ill;
    logic [CNT_W:0] cnt_sum;

    always_comb begin
        pop_ill = '0;
        for (int i = 0; i < LANES; i++) begin
            pop_ill = pop_ill + {2'b00, out_illegal[i]};
        end
        cnt_sum = {1'b0, illegal_cnt} + {{(CNT_W-2){1'b0}}, pop_ill};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_cnt <= '0;
        end else if (fifo_rd) begin
            illegal_cnt <= cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
        end
    end

endmodule

// File: tb/tb_decode_2r12i_stage.sv
// Self-checking bench for decode_2r12i_stage: directed vector table,
// hand sequences for back-pressure/flush/reset, and a scoreboarded random run.
module tb_decode_2r12i_stage;
    import decode_2r12i_stage_pkg::*;

    localparam int LANES = 2;
    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    logic        clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [1:0]  in_mask, out_mask, out_illegal;
    logic [63:0] in_instr, in_pc, out_imm, out_pc;
    logic [7:0]  out_op;
    logic [9:0]  out_rd, out_rj;
    logic [15:0] illegal_cnt;

    decode_2r12i_stage #(.LANES(LANES), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_mask(in_mask),
        .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_mask(out_mask),
        .out_op(out_op), .out_rd(out_rd), .out_rj(out_rj), .out_imm(out_imm),
        .out_pc(out_pc), .out_illegal(out_illegal), .illegal_cnt(illegal_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: full 10-bit major opcode lookup (instr[31:22]).
    logic [3:0] op_tab [1024];
    logic [9:0] opc_list [15];

    typedef struct packed {
        logic [1:0]  mask;
        logic [7:0]  op;
        logic [9:0]  rd;
        logic [9:0]  rj;
        logic [63:0] imm;
        logic [63:0] pc;
        logic [1:0]  ill;
    } bundle_t;

    typedef struct {
        bundle_t b;
        int      cyc;
    } entry_t;

    entry_t    sb [$];
    bit        mon_en = 1'b0;
    int        m_cnt = 0;

    function automatic bundle_t model(input logic [63:0] ins, input logic [1:0] m,
                                      input logic [63:0] pc);
        bundle_t b;
        b      = '0;
        b.mask = m;
        b.pc   = pc;
        for (int i = 0; i < 2; i++) begin
            logic [31:0] w;
            logic [3:0]  o;
            logic [11:0] s;
            w = ins[32*i +: 32];
            s = w[21:10];
            o = op_tab[w[31:22]];
            if (!m[i]) begin
                b.op[4*i +: 4] = INVALID_OP_4B;
            end else begin
                b.op[4*i +: 4] = o;
                b.rd[5*i +: 5] = w[4:0];
                b.rj[5*i +: 5] = w[9:5];
                if (o == INVALID_OP_4B) b.ill[i] = 1'b1;
                else if (o inside {_2R12I_ANDI, _2R12I_ORI, _2R12I_XORI}) b.imm[32*i +: 32] = 32'(s);
                else b.imm[32*i +: 32] = 32'(signed'(s));
            end
        end
        return b;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 3))
            0, 1: r[31:22] = opc_list[$urandom_range(0, 14)];
            2:    r[31:22] = {($urandom_range(0, 1) != 0) ? 6'b000000 : 6'b001010, 4'($urandom)};
            default: ;
        endcase
        return r;
    endfunction

    // Scoreboard monitor: samples on the falling edge, mid-cycle.
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            logic exp_ov;
            exp_ov = (sb.size() > 0) && ((cyc - sb[0].cyc) >= 2);
            check("mon_in_ready", in_ready, sb.size() < DEPTH);
            check("mon_out_valid", out_valid, exp_ov);
            check("mon_illegal_cnt", illegal_cnt, m_cnt);
            if (out_valid && exp_ov) begin
                check("mon_mask", out_mask, sb[0].b.mask);
                check("mon_op", out_op, sb[0].b.op);
                check("mon_rd_rj", {out_rd, out_rj}, {sb[0].b.rd, sb[0].b.rj});
                check("mon_imm", out_imm, sb[0].b.imm);
                check("mon_pc", out_pc, sb[0].b.pc);
                check("mon_illegal", out_illegal, sb[0].b.ill);
            end else if (!out_valid) begin
                check("mon_empty_ctl", {out_mask, out_op, out_rd, out_rj, out_illegal}, '0);
                check("mon_empty_data", {out_imm, out_pc}, '0);
            end
            if (flush) begin
                sb.delete();
            end else begin
                if (out_valid && out_ready && sb.size() > 0) begin
                    m_cnt = m_cnt + int'(sb[0].b.ill[0]) + int'(sb[0].b.ill[1]);
                    if (m_cnt > 65535) m_cnt = 65535;
                    void'(sb.pop_front());
                end
                if (in_valid && in_ready) begin
                    entry_t e;
                    e.b   = model(in_instr, in_mask, in_pc);
                    e.cyc = cyc;
                    sb.push_back(e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_random(input bit force_valid);
        in_valid = force_valid || ($urandom_range(0, 9) < 7);
        in_mask  = 2'($urandom);
        in_instr = {rand_instr(), rand_instr()};
        in_pc    = {$urandom, $urandom};
    endtask

    typedef struct {
        logic [31:0] i0, i1;
        logic [1:0]  mask;
        logic [7:0]  op;
        logic [9:0]  rd;
        logic [63:0] imm;
        logic [1:0]  ill;
    } vec_t;

    vec_t vecs [7];
    int   exp_cnt;
    int   acc;

    initial begin
        for (int i = 0; i < 1024; i++) op_tab[i] = INVALID_OP_4B;
        op_tab[10'h008] = _2R12I_SLTI;  op_tab[10'h009] = _2R12I_SLTUI;
        op_tab[10'h00A] = _2R12I_ADDI;  op_tab[10'h00D] = _2R12I_ANDI;
        op_tab[10'h00E] = _2R12I_ORI;   op_tab[10'h00F] = _2R12I_XORI;
        op_tab[10'h0A0] = _2R12I_LD_B;  op_tab[10'h0A1] = _2R12I_LD_H;
        op_tab[10'h0A2] = _2R12I_LD_W;  op_tab[10'h0A4] = _2R12I_ST_B;
        op_tab[10'h0A5] = _2R12I_ST_H;  op_tab[10'h0A6] = _2R12I_ST_W;
        op_tab[10'h0A8] = _2R12I_LD_BU; op_tab[10'h0A9] = _2R12I_LD_HU;
        op_tab[10'h0AB] = _2R12I_PRELD;
        opc_list = '{10'h008, 10'h009, 10'h00A, 10'h00D, 10'h00E, 10'h00F, 10'h0A0,
                     10'h0A1, 10'h0A2, 10'h0A4, 10'h0A5, 10'h0A6, 10'h0A8, 10'h0A9, 10'h0AB};

        //            lane0         lane1         mask   {op1,op0} {rd1,rd0} {imm1,imm0}                ill
        vecs[0] = '{32'h02BFFC41, 32'h037FFC00, 2'b11, 8'h32, 10'h001, 64'h00000FFF_FFFFFFFF, 2'b00};
        vecs[1] = '{32'h28800000, 32'h02400000, 2'b11, 8'h18, 10'h000, 64'h00000000_00000000, 2'b00};
        vecs[2] = '{32'h28800000, 32'h02C00000, 2'b11, 8'hF8, 10'h000, 64'h00000000_00000000, 2'b10};
        vecs[3] = '{32'h02BFFC41, 32'hDEADBEEF, 2'b01, 8'hF2, 10'h001, 64'h00000000_FFFFFFFF, 2'b00};
        vecs[4] = '{32'h03A0003F, 32'h29A00000, 2'b11, 8'hB4, 10'h01F, 64'hFFFFF800_00000800, 2'b00};
        vecs[5] = '{32'h02BFFC41, 32'h28800000, 2'b00, 8'hFF, 10'h000, 64'h00000000_00000000, 2'b00};
        vecs[6] = '{32'h0200001F, 32'h28C00000, 2'b11, 8'hF0, 10'h01F, 64'h00000000_00000000, 2'b10};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_mask = '0; in_instr = '0; in_pc = '0;
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_illegal_cnt", illegal_cnt, 0);
        check("rst_outputs", {out_op, out_imm, out_pc}, '0);
        rst_n = 1'b1;
        tick();
        mon_en = 1'b1;

        // Directed decode vectors, one bundle at a time, checking 2-cycle latency.
        exp_cnt = 0;
        for (int v = 0; v < 7; v++) begin
            in_valid = 1'b1;
            in_mask  = vecs[v].mask;
            in_instr = {vecs[v].i1, vecs[v].i0};
            in_pc    = {32'h1000_0004 + 32'(v * 8), 32'h1000_0000 + 32'(v * 8)};
            check("dir_in_ready", in_ready, 1);
            tick();
            in_valid = 1'b0;
            check("dir_lat1_no_valid", out_valid, 0);
            tick();
            check("dir_out_valid", out_valid, 1);
            check("dir_op", out_op, vecs[v].op);
            check("dir_rd", out_rd, vecs[v].rd);
            check("dir_imm", out_imm, vecs[v].imm);
            check("dir_illegal", out_illegal, vecs[v].ill);
            check("dir_mask", out_mask, vecs[v].mask);
            check("dir_pc", out_pc, {32'h1000_0004 + 32'(v * 8), 32'h1000_0000 + 32'(v * 8)});
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            exp_cnt = exp_cnt + int'(vecs[v].ill[0]) + int'(vecs[v].ill[1]);
            check("dir_illegal_cnt", illegal_cnt, exp_cnt);
            check("dir_drained", out_valid, 0);
        end

        // Back-pressure: 6 offered with out_ready low, exactly DEPTH accepted.
        acc = 0;
        for (int k = 0; k < 6; k++) begin
            drive_random(1'b1);
            if (in_ready) acc++;
            tick();
        end
        in_valid = 1'b0;
        check("bp_accepted", acc, DEPTH);
        check("bp_in_ready_low", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        out_ready = 1'b1;
        repeat (6) tick();
        check("bp_drained", out_valid, 0);

        // Full FIFO with continuous enqueue and dequeue.
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin drive_random(1'b1); tick(); end
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin drive_random(1'b1); tick(); end
        in_valid = 1'b0;
        repeat (6) tick();

        // Flush with a bundle presented: it must never appear.
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin drive_random(1'b1); tick(); end
        in_valid = 1'b1;
        in_pc    = 64'hF1F1F1F1_F1F1F1F1;
        flush    = 1'b1;
        exp_cnt  = int'(illegal_cnt);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", out_valid, 0);
        check("flush_in_ready", in_ready, 1);
        check("flush_keeps_cnt", illegal_cnt, exp_cnt);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("flush_nothing_emerges", out_valid, 0);
        end

        // Randomized traffic against the scoreboard.
        for (int k = 0; k < 400; k++) begin
            drive_random(1'b0);
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 59) == 0);
            tick();
        end
        flush = 1'b0;

        // Asynchronous reset between edges, mid-stream.
        for (int k = 0; k < 6; k++) begin drive_random(1'b1); out_ready = 1'b0; tick(); end
        mon_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_illegal_cnt", illegal_cnt, 0);
        check("arst_in_ready", in_ready, 1);
        check("arst_outputs", {out_op, out_imm}, '0);
        sb.delete();
        m_cnt    = 0;
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        mon_en = 1'b1;
        for (int k = 0; k < 150; k++) begin
            drive_random(1'b0);
            out_ready = ($urandom_range(0, 9) < 7);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (8) tick();
        check("final_drained", out_valid, 0);
        mon_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
